// File: rtl/toe_pkg.sv
// Shared TOE definitions: protocol constants, connection record layout and parser states.
// The packet builder reads records using the same offsets.
package toe_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
    localparam int          REC_WORDS     = 9;

    localparam logic [3:0] REC_VALID      = 4'd0;
    localparam logic [3:0] REC_SEQ        = 4'd1;
    localparam logic [3:0] REC_ACK        = 4'd2;
    localparam logic [3:0] REC_IP_SRC     = 4'd3;
    localparam logic [3:0] REC_IP_DST     = 4'd4;
    localparam logic [3:0] REC_MAC_SRC_HI = 4'd5;
    localparam logic [3:0] REC_MAC_MIX    = 4'd6;
    localparam logic [3:0] REC_MAC_DST_LO = 4'd7;
    localparam logic [3:0] REC_PORTS      = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DRAIN,
        ST_WRITE
    } parser_state_e;

    typedef struct packed {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
    } hdr_fields_t;

    function automatic logic [31:0] rec_word(input logic [3:0] off, input hdr_fields_t h);
        case (off)
            REC_VALID:      rec_word = {1'b1, 23'b0, h.flags};
            REC_SEQ:        rec_word = h.seq;
            REC_ACK:        rec_word = h.ack;
            REC_IP_SRC:     rec_word = h.ip_src;
            REC_IP_DST:     rec_word = h.ip_dst;
            REC_MAC_SRC_HI: rec_word = h.mac_src[47:16];
            REC_MAC_MIX:    rec_word = {h.mac_src[15:0], h.mac_dst[47:32]};
            REC_MAC_DST_LO: rec_word = h.mac_dst[31:0];
            REC_PORTS:      rec_word = {h.src_port, h.dst_port};
            default:        rec_word = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/packet_parser.sv
// Receive-side TOE parser: extracts Ethernet/IPv4/TCP header fields from a 32-bit word
// stream and writes a 9-word connection record into the selected RAM slot.
module packet_parser
    import toe_pkg::*;
#(
    parameter int SLOT_STRIDE = 32,
    parameter int HDR_WORDS   = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    input  logic [2:0]  slot,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    output logic        pkt_done,
    output logic [15:0] drop_cnt
);

    localparam int         SLOT_SHIFT = $clog2(SLOT_STRIDE);
    localparam logic [3:0] LAST_WORD  = 4'(HDR_WORDS - 1);

    parser_state_e state;
    logic [3:0]    widx;
    logic [3:0]    wcnt;
    logic [3:0]    cur_idx;
    logic [2:0]    slot_q;
    hdr_fields_t   fld;
    logic [15:0]   eth_type;
    logic [3:0]    ip_ver;
    logic [3:0]    ip_ihl;
    logic [7:0]    ip_proto;
    logic          hdr_ok;
    logic          xfer;
    logic          in_frame;
    logic          frame_end;
    logic          accept;
    logic          drop_old;
    logic          drop_new;
    logic [16:0]   drop_sum;
    logic [8:0]    base;

    assign in_ready  = (state != ST_WRITE);
    assign xfer      = in_valid && in_ready;
    assign in_frame  = (state == ST_HDR) || (state == ST_DRAIN);
    assign cur_idx   = in_sop ? 4'd0 : widx;
    assign hdr_ok    = (eth_type == ETH_TYPE_IPV4) && (ip_ver == 4'd4) &&
                       (ip_ihl == 4'd5) && (ip_proto == IP_PROTO_TCP);

    // A non-SOP EOP closes the frame in progress; it is written only if the header was complete.
    assign frame_end = xfer && !in_sop && in_eop && in_frame;
    assign accept    = frame_end && hdr_ok && ((state == ST_DRAIN) || (widx == LAST_WORD));
    assign drop_old  = xfer && in_sop && in_frame;
    assign drop_new  = (frame_end && !accept) || (xfer && in_sop && in_eop);
    assign drop_sum  = {1'b0, drop_cnt} + 17'(drop_old) + 17'(drop_new);
    assign base      = 9'(slot_q) << SLOT_SHIFT;

    // NOTE: capture registers carry no reset; they only hold meaning after an SOP reloads them.
    always_ff @(posedge clk) begin
        if (xfer && (in_sop || state == ST_HDR)) begin
            if (in_sop) slot_q <= slot;
            case (cur_idx)
                4'd0: fld.mac_dst[47:16] <= in_data;
                4'd1: begin
                    fld.mac_dst[15:0]  <= in_data[31:16];
                    fld.mac_src[47:32] <= in_data[15:0];
                end
                4'd2: fld.mac_src[31:0] <= in_data;
                4'd3: begin
                    eth_type <= in_data[31:16];
                    ip_ver   <= in_data[15:12];
                    ip_ihl   <= in_data[11:8];
                end
                4'd5: ip_proto <= in_data[7:0];
                4'd6: fld.ip_src[31:16] <= in_data[15:0];
                4'd7: begin
                    fld.ip_src[15:0]  <= in_data[31:16];
                    fld.ip_dst[31:16] <= in_data[15:0];
                end
                4'd8: begin
                    fld.ip_dst[15:0] <= in_data[31:16];
                    fld.src_port     <= in_data[15:0];
                end
                4'd9: begin
                    fld.dst_port  <= in_data[31:16];
                    fld.seq[31:16] <= in_data[15:0];
                end
                4'd10: begin
                    fld.seq[15:0]  <= in_data[31:16];
                    fld.ack[31:16] <= in_data[15:0];
                end
                4'd11: begin
                    fld.ack[15:0] <= in_data[31:16];
                    fld.flags     <= in_data[7:0];
                end
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            widx     <= 4'd0;
            wcnt     <= 4'd0;
            ram_wren <= 1'b0;
            ram_addr <= 9'd0;
            ram_data <= 32'd0;
            pkt_done <= 1'b0;
            drop_cnt <= 16'd0;
        end else begin
            ram_wren <= 1'b0;
            pkt_done <= 1'b0;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            case (state)
                ST_WRITE: begin
                    if (wcnt == 4'(REC_WORDS)) begin
                        state <= ST_IDLE;
                    end else begin
                        ram_wren <= 1'b1;
                        ram_addr <= base + 9'(wcnt);
                        ram_data <= rec_word(wcnt, fld);
                        pkt_done <= (wcnt == 4'(REC_WORDS - 1));
                        wcnt     <= wcnt + 4'd1;
                    end
                end
                default: begin
                    if (xfer) begin
                        if (in_sop) begin
                            state <= in_eop ? ST_IDLE : ST_HDR;
                            widx  <= 4'd1;
                        end else if (accept) begin
                            state    <= ST_WRITE;
                            ram_wren <= 1'b1;
                            ram_addr <= base;
                            ram_data <= rec_word(REC_VALID, fld);
                            wcnt     <= 4'd1;
                        end else if (state == ST_HDR) begin
                            if (in_eop)                 state <= ST_IDLE;
                            else if (widx == LAST_WORD) state <= ST_DRAIN;
                            else                        widx  <= widx + 4'd1;
                        end else if (in_eop) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_parser.sv
// Self-checking bench for packet_parser: frames are built byte-by-byte from header fields
// and the expected records, addresses, timing and drop counts come from those fields.
module tb_packet_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        in_ready;
    logic [2:0]  slot = 3'd0;
    logic [8:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        pkt_done;
    logic [15:0] drop_cnt;

    packet_parser dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_ready (in_ready),
        .slot     (slot),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .pkt_done (pkt_done),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [15:0] etype;
        logic [7:0]  ver_ihl;
        logic [7:0]  proto;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
    } hdr_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        logic        done;
        int          cyc;
    } wr_t;

    wr_t         wq[$];
    wr_t         mon_e;
    logic [31:0] fq[$];
    int cyc = 0, rdy_low = 0, done_cnt = 0, eop_cyc = 0;
    int vectors = 0, miscompares = 0, exp_drop = 0;

    // Monitor: one sample per cycle, on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst && in_ready === 1'b0) rdy_low = rdy_low + 1;
        if (ram_wren === 1'b1) begin
            mon_e.addr = ram_addr;
            mon_e.data = ram_data;
            mon_e.done = pkt_done;
            mon_e.cyc  = cyc;
            wq.push_back(mon_e);
        end
        if (pkt_done === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
        $fatal(1);
    end

    function automatic hdr_t rand_hdr();
        hdr_t h;
        h.mac_dst = 48'({$urandom, $urandom});
        h.mac_src = 48'({$urandom, $urandom});
        h.etype   = 16'h0800;
        h.ver_ihl = 8'h45;
        h.proto   = 8'd6;
        h.ip_src  = $urandom;
        h.ip_dst  = $urandom;
        h.sport   = 16'($urandom);
        h.dport   = 16'($urandom);
        h.seq     = $urandom;
        h.ack     = $urandom;
        h.flags   = 8'($urandom);
        return h;
    endfunction

    function automatic hdr_t plan_hdr();
        hdr_t h;
        h.mac_dst = 48'h0A1B2C3D4E5F;
        h.mac_src = 48'h001122334455;
        h.etype   = 16'h0800;
        h.ver_ihl = 8'h45;
        h.proto   = 8'd6;
        h.ip_src  = 32'hC0A80001;
        h.ip_dst  = 32'hC0A80002;
        h.sport   = 16'h1F90;
        h.dport   = 16'h0050;
        h.seq     = 32'h11223344;
        h.ack     = 32'h55667788;
        h.flags   = 8'h18;
        return h;
    endfunction

    function automatic bit hdr_valid(input hdr_t h);
        return h.etype == 16'h0800 && h.ver_ihl == 8'h45 && h.proto == 8'd6;
    endfunction

    // Lay the header out as wire bytes (54 + 2 pad), then pack big-endian into words.
    task automatic build_frame(input hdr_t h, input int nwords);
        logic [7:0] b [56];
        for (int i = 0; i < 56; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            b[i]     = h.mac_dst[47-8*i -: 8];
            b[6 + i] = h.mac_src[47-8*i -: 8];
        end
        b[12] = h.etype[15:8];
        b[13] = h.etype[7:0];
        b[14] = h.ver_ihl;
        b[23] = h.proto;
        for (int i = 0; i < 4; i++) begin
            b[26 + i] = h.ip_src[31-8*i -: 8];
            b[30 + i] = h.ip_dst[31-8*i -: 8];
            b[38 + i] = h.seq[31-8*i -: 8];
            b[42 + i] = h.ack[31-8*i -: 8];
        end
        b[34] = h.sport[15:8];
        b[35] = h.sport[7:0];
        b[36] = h.dport[15:8];
        b[37] = h.dport[7:0];
        b[47] = h.flags;
        fq.delete();
        for (int w = 0; w < nwords; w++) begin
            if (w < 14) fq.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
            else        fq.push_back($urandom);
        end
    endtask

    task automatic send_frame(input logic [2:0] s, input bit gaps, input bit with_eop);
        for (int i = 0; i < fq.size(); i++) begin
            int g;
            int n;
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sop   = 1'b0;
                in_eop   = 1'b0;
                in_data  = $urandom;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fq[i];
            in_sop   = (i == 0);
            in_eop   = with_eop && (i == fq.size() - 1);
            slot     = (i == 0) ? s : 3'($urandom);
            n = 0;
            while (in_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n == 50) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_timeout: in_ready low for 50 cycles, expected 1");
            end
            @(posedge clk);
            if (in_eop) eop_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic clear_mon();
        wq.delete();
        done_cnt = 0;
        rdy_low  = 0;
    endtask

    task automatic verify_frame(input string name, input hdr_t h, input logic [2:0] s, input bit acc);
        logic [31:0] rec [9];
        int exp_n;
        rec[0] = {1'b1, 23'b0, h.flags};
        rec[1] = h.seq;
        rec[2] = h.ack;
        rec[3] = h.ip_src;
        rec[4] = h.ip_dst;
        rec[5] = h.mac_src[47:16];
        rec[6] = {h.mac_src[15:0], h.mac_dst[47:32]};
        rec[7] = h.mac_dst[31:0];
        rec[8] = {h.sport, h.dport};
        exp_n  = acc ? 9 : 0;
        repeat (14) @(negedge clk);
        vectors++;
        if (wq.size() !== exp_n) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d, expected %0d", name, wq.size(), exp_n);
        end
        if (acc && wq.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                vectors++;
                if (wq[k].addr !== 9'(int'(s) * 32 + k)) begin
                    miscompares++;
                    $display("FAIL %s addr[%0d]: got %0d, expected %0d", name, k, wq[k].addr, int'(s) * 32 + k);
                end
                vectors++;
                if (wq[k].data !== rec[k]) begin
                    miscompares++;
                    $display("FAIL %s data[%0d]: got %h, expected %h", name, k, wq[k].data, rec[k]);
                end
                vectors++;
                if (wq[k].done !== (k == 8)) begin
                    miscompares++;
                    $display("FAIL %s pkt_done[%0d]: got %b, expected %b", name, k, wq[k].done, k == 8);
                end
                vectors++;
                if (wq[k].cyc !== eop_cyc + 1 + k) begin
                    miscompares++;
                    $display("FAIL %s write_cycle[%0d]: got %0d, expected %0d", name, k, wq[k].cyc, eop_cyc + 1 + k);
                end
            end
        end
        vectors++;
        if (done_cnt !== int'(acc)) begin
            miscompares++;
            $display("FAIL %s pkt_done_count: got %0d, expected %0d", name, done_cnt, int'(acc));
        end
        vectors++;
        if (drop_cnt !== 16'(exp_drop)) begin
            miscompares++;
            $display("FAIL %s drop_cnt: got %0d, expected %0d", name, drop_cnt, exp_drop);
        end
        vectors++;
        if (rdy_low !== exp_n) begin
            miscompares++;
            $display("FAIL %s ready_low_cycles: got %0d, expected %0d", name, rdy_low, exp_n);
        end
        clear_mon();
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL %s ram_wren: got %b, expected 0", name, ram_wren); end
        vectors++;
        if (ram_addr !== 9'd0) begin miscompares++; $display("FAIL %s ram_addr: got %0d, expected 0", name, ram_addr); end
        vectors++;
        if (ram_data !== 32'd0) begin miscompares++; $display("FAIL %s ram_data: got %h, expected 0", name, ram_data); end
        vectors++;
        if (pkt_done !== 1'b0) begin miscompares++; $display("FAIL %s pkt_done: got %b, expected 0", name, pkt_done); end
        vectors++;
        if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL %s drop_cnt: got %0d, expected 0", name, drop_cnt); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s in_ready: got %b, expected 1", name, in_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        exp_drop = 0;
        @(negedge clk);
        clear_mon();
    endtask

    task automatic test_valid_frame();
        hdr_t h = plan_hdr();
        build_frame(h, 14);
        send_frame(3'd3, 1'b0, 1'b1);
        verify_frame("valid_frame", h, 3'd3, 1'b1);
    endtask

    task automatic test_bad_ethertype();
        hdr_t h = plan_hdr();
        h.etype = 16'h0806;
        build_frame(h, 14);
        send_frame(3'd3, 1'b0, 1'b1);
        exp_drop++;
        verify_frame("bad_ethertype", h, 3'd3, 1'b0);
    endtask

    task automatic test_runt();
        hdr_t h = rand_hdr();
        logic [2:0] s = 3'($urandom);
        build_frame(h, 8);
        send_frame(s, 1'b0, 1'b1);
        exp_drop++;
        verify_frame("runt", h, s, 1'b0);
        h = rand_hdr();
        build_frame(h, 14);
        send_frame(s, 1'b0, 1'b1);
        verify_frame("after_runt", h, s, 1'b1);
    endtask

    task automatic test_payload_gaps();
        hdr_t h = rand_hdr();
        logic [2:0] s = 3'($urandom);
        build_frame(h, 34);
        send_frame(s, 1'b1, 1'b1);
        verify_frame("payload_gaps", h, s, 1'b1);
    endtask

    task automatic test_sop_abort();
        hdr_t ha = rand_hdr();
        hdr_t hb = rand_hdr();
        build_frame(ha, 9);
        send_frame(3'd2, 1'b0, 1'b0);
        build_frame(hb, 14);
        send_frame(3'd5, 1'b0, 1'b1);
        exp_drop++;
        verify_frame("sop_abort", hb, 3'd5, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        hdr_t h = rand_hdr();
        build_frame(h, 14);
        send_frame(3'd1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_write");
        rst = 1'b1;
        exp_drop = 0;
        repeat (12) @(negedge clk);
        vectors++;
        if (wq.size() !== 4) begin
            miscompares++;
            $display("FAIL reset_mid_write write_count: got %0d, expected 4", wq.size());
        end else begin
            vectors++;
            if (wq[3].addr !== 9'd35) begin
                miscompares++;
                $display("FAIL reset_mid_write last_addr: got %0d, expected 35", wq[3].addr);
            end
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_write pkt_done_count: got %0d, expected 0", done_cnt);
        end
        clear_mon();
        h = rand_hdr();
        build_frame(h, 16);
        send_frame(3'd6, 1'b0, 1'b1);
        verify_frame("after_reset", h, 3'd6, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            hdr_t h = rand_hdr();
            int len;
            int kind = $urandom_range(0, 5);
            int lk = $urandom_range(0, 3);
            bit acc;
            logic [2:0] s = 3'($urandom);
            if (kind == 0) h.etype = 16'($urandom);
            else if (kind == 1) h.ver_ihl = 8'h46;
            else if (kind == 2) h.proto = 8'd17;
            if (lk == 0)      len = $urandom_range(2, 13);
            else if (lk == 1) len = 14;
            else              len = 14 + $urandom_range(1, 6);
            acc = (len >= 14) && hdr_valid(h);
            if (!acc) exp_drop++;
            build_frame(h, len);
            send_frame(s, 1'($urandom), 1'b1);
            verify_frame("random", h, s, acc);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_ethertype();
        test_runt();
        test_payload_gaps();
        test_sop_abort();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_parser.md
# packet_parser

Receive-side counterpart of the TOE packet builder. It accepts an inbound Ethernet/IPv4/TCP frame as a 32-bit big-endian word stream and extracts the header fields. After validation it writes a 9-word connection record into the connection RAM slot selected by `slot`, in the same record layout the builder reads. It sits between the MAC receive path and the connection RAM write port.

## Interface
Parameters:
- `SLOT_STRIDE`, 32: RAM words per connection slot.
- `HDR_WORDS`, 14: stream words spanning the 54-byte Ethernet+IP+TCP header (words 0..13).

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `in_data`  in  32: frame word; byte 0 of the frame is in bits [31:24].
- `in_valid`  in  1: `in_data`, `in_sop` and `in_eop` are valid.
- `in_sop`  in  1: first word of the frame (destination MAC [47:16]).
- `in_eop`  in  1: last word of the frame.
- `in_ready`  out  1: parser accepts a word; a word transfers when `in_valid && in_ready`.
- `slot`  in  3: connection slot; base address = `slot*SLOT_STRIDE`. Sampled on the SOP transfer.
- `ram_addr`  out  9: RAM write address.
- `ram_data`  out  32: RAM write data.
- `ram_wren`  out  1: RAM write enable.
- `pkt_done`  out  1: one-cycle pulse when a record write completes.
- `drop_cnt`  out  16: count of discarded frames; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: waits for an SOP transfer and ignores non-SOP transfers.
  - HDR: counts header words `widx` 0..13.
  - DRAIN: discards payload until EOP.
  - WRITE: 9 write cycles.
- Field capture, by word index:
  - w0: `mac_dst[47:16]`.
  - w1: `mac_dst[15:0]` and `mac_src[47:32]`.
  - w2: `mac_src[31:0]`.
  - w3: ethertype [31:16], version [15:12], IHL [11:8].
  - w5: protocol [7:0].
  - w6: `ip_src[31:16]` [15:0].
  - w7: `ip_src[15:0]` [31:16], `ip_dst[31:16]` [15:0].
  - w8: `ip_dst[15:0]` [31:16], `src_port` [15:0].
  - w9: `dst_port` [31:16], `seq[31:16]` [15:0].
  - w10: `seq[15:0]` [31:16], `ack[31:16]` [15:0].
  - w11: `ack[15:0]` [31:16], TCP flags [7:0].
- Validation (`hdr_ok`): ethertype == 0x0800, version == 4, IHL == 5, protocol == 6.
- Transitions:
  - IDLE → HDR on an SOP transfer (`widx` = 1 next).
  - In HDR, the transfer of w13:
    - with EOP: → WRITE if `hdr_ok`, else drop → IDLE.
    - without EOP: → DRAIN.
  - In HDR, EOP before w13 (runt): drop → IDLE.
  - DRAIN: EOP → WRITE if `hdr_ok`, else drop → IDLE.
  - SOP while in HDR or DRAIN: the current frame is dropped. The SOP word is taken as w0 of a new frame and `slot` is re-sampled.
  - WRITE: offsets 0..8 in order, then → IDLE.
- Record layout (offset: data):
  - 0: {1'b1, 23'b0, flags}.
  - 1: seq.
  - 2: ack.
  - 3: ip_src.
  - 4: ip_dst.
  - 5: mac_src[47:16].
  - 6: {mac_src[15:0], mac_dst[47:32]}.
  - 7: mac_dst[31:0].
  - 8: {src_port, dst_port}.
- Each drop increments `drop_cnt` by one.
- A drop never asserts `ram_wren`.

## Timing
- Reset values: `ram_wren`=0, `ram_addr`=0, `ram_data`=0, `pkt_done`=0, `drop_cnt`=0, state IDLE.
- `in_ready` = (state != WRITE), so it is 1 while and after reset.
- `ram_*` and `pkt_done` are registered outputs.
- EOP of an accepted frame transfers at edge T:
  - `ram_wren`=1 on cycles T+1..T+9 with `ram_addr` = base+0..base+8.
  - `pkt_done` = 1 on cycle T+9 only.
  - `in_ready` = 0 on cycles T+1..T+9 and returns to 1 on T+10.
- `in_valid` asserted while `in_ready`=0 is not a transfer. The source holds the word.
- Capture registers persist until the next SOP. Unused fields of a dropped frame are don't-care.
- `drop_cnt` updates on the cycle after the dropping transfer.
- Reset asserted mid-WRITE: the write sequence aborts immediately, no further `ram_wren`, no `pkt_done`.
- `ram_addr` arithmetic is `{1'b0, slot, 5'b0} + offset`, so there is no carry out of the slot.

## Structure
- Shared package `toe_pkg` holds:
  - `ETH_TYPE_IPV4` (16'h0800), `IP_PROTO_TCP` (8'd6), `REC_WORDS` (9).
  - The record offset constants `REC_VALID`..`REC_PORTS`.
  - The parser state enum.
- The builder imports the same record offsets.
- Single module; no sub-module.

## Test plan
- Valid 54-byte frame (14 words, EOP on w13) with mac_dst 0x0A1B2C3D4E5F, mac_src 0x001122334455, ip_src 0xC0A80001, ip_dst 0xC0A80002, ports 0x1F90/0x0050, seq 0x11223344, ack 0x55667788, flags 0x18, slot 3:
  - 9 writes to addresses 96..104, offset 0 = 0x80000018, offset 8 = 0x1F900050.
  - `pkt_done` on the 9th write cycle.
  - `drop_cnt` = 0.
- Same frame with ethertype 0x0806 → no `ram_wren`, `drop_cnt` = 1, `in_ready` stays 1.
- Runt: EOP on w7 → no write, `drop_cnt` +1. The next valid frame is parsed normally.
- Frame with 20 payload words and `in_valid` gaps → writes start the cycle after EOP; `in_ready` is low exactly 9 cycles.
- SOP at w9 of frame A, then a full valid frame B on slot 5 → `drop_cnt` +1; only B is written, at addresses 160..168.
- Reset asserted on the 4th write cycle → `ram_wren` is 0 the next cycle, no `pkt_done`, outputs at reset values; the following frame is parsed correctly.
